// File: rtl/temp_poll_seq_if.sv
// Command/handshake bundle between the temperature poll sequencer (master)
// and the I2C temperature controller (slave).
interface temp_poll_seq_if;
    logic        i2c_start;
    logic [31:0] i2c_cfg_data;
    logic        i2c_done;
    logic [7:0]  i2c_rd_data;

    modport master (
        output i2c_start,
        output i2c_cfg_data,
        input  i2c_done,
        input  i2c_rd_data
    );

    modport slave (
        input  i2c_start,
        input  i2c_cfg_data,
        output i2c_done,
        output i2c_rd_data
    );
endinterface

// File: rtl/temp_poll_seq.sv
// temp_poll_seq: issues one sensor configuration write after reset, then
// polls the temperature MSB/LSB registers every POLL_CYCLES clocks through
// the I2C controller's command-word / start-done handshake. Each WAIT state
// is guarded by a timeout that reports nack_err and bumps a saturating
// error counter.
// Optional build macro TEMP_AVG_EN: when defined, temp_data is the mean of
// the last four completed samples instead of the raw latest sample.
module temp_poll_seq #(
    parameter logic [6:0]  DEV_ADDR       = 7'h48,
    parameter logic [15:0] CFG_REG        = 16'h0001,
    parameter logic [7:0]  CFG_VAL        = 8'h60,
    parameter logic [15:0] TEMP_REG_MSB   = 16'h0000,
    parameter logic [15:0] TEMP_REG_LSB   = 16'h0001,
    parameter int unsigned POLL_CYCLES    = 5000000,
    parameter int unsigned TIMEOUT_CYCLES = 50000
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   enable,
    temp_poll_seq_if.master        i2c,
    output logic [15:0]            temp_data,
    output logic                   temp_valid,
    output logic                   busy,
    output logic                   nack_err,
    output logic [7:0]             err_cnt
);

    localparam int PW = (POLL_CYCLES > 1) ? $clog2(POLL_CYCLES) : 1;
    localparam int TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [PW-1:0] POLL_LAST = PW'(POLL_CYCLES - 1);
    localparam logic [TW-1:0] TMO_LAST  = TW'(TIMEOUT_CYCLES - 1);

    // Command words: {dev_addr, rd_flag, reg_hi, reg_lo, wr_data}
    localparam logic [31:0] CMD_CFG   = {DEV_ADDR, 1'b0, CFG_REG, CFG_VAL};
    localparam logic [31:0] CMD_RD_HI = {DEV_ADDR, 1'b1, TEMP_REG_MSB, 8'h00};
    localparam logic [31:0] CMD_RD_LO = {DEV_ADDR, 1'b1, TEMP_REG_LSB, 8'h00};

    typedef enum logic [3:0] {
        S_CFG,
        S_CFG_WAIT,
        S_IDLE,
        S_RD_HI,
        S_RD_HI_WAIT,
        S_GAP,
        S_RD_LO,
        S_RD_LO_WAIT,
        S_ERR
    } state_t;

    state_t         state_reg;
    state_t         ret_reg;
    logic [PW-1:0]  poll_cnt_reg;
    logic [TW-1:0]  tmo_cnt_reg;
    logic [7:0]     msb_reg;

    logic           tmo_hit;
    logic           sample_commit;
    logic [15:0]    sample_word;
    logic [15:0]    temp_next;

    assign tmo_hit       = (tmo_cnt_reg == TMO_LAST);
    assign sample_word   = {msb_reg, i2c.i2c_rd_data};
    assign sample_commit = (state_reg == S_RD_LO_WAIT) && i2c.i2c_done;

`ifdef TEMP_AVG_EN
    logic [15:0] hist_reg [4];
    logic [17:0] sum_reg;
    logic [17:0] sum_next;

    // Running sum: add the new sample, drop the one falling off the window
    always_comb begin
        sum_next = sum_reg + 18'(sample_word) - 18'(hist_reg[3]);
    end

    assign temp_next = sum_next[17:2];

    // Four-deep sample window, zero-filled at reset
    always_ff @(posedge clk) begin
        if (rst) begin
            sum_reg <= '0;
            for (int i = 0; i < 4; i++) begin
                hist_reg[i] <= '0;
            end
        end else if (sample_commit) begin
            sum_reg     <= sum_next;
            hist_reg[0] <= sample_word;
            for (int i = 1; i < 4; i++) begin
                hist_reg[i] <= hist_reg[i-1];
            end
        end
    end
`else
    assign temp_next = sample_word;
`endif

    // Sequencer FSM with registered handshake and status outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg        <= S_CFG;
            ret_reg          <= S_CFG;
            poll_cnt_reg     <= '0;
            tmo_cnt_reg      <= '0;
            msb_reg          <= '0;
            i2c.i2c_start    <= 1'b0;
            i2c.i2c_cfg_data <= '0;
            temp_data        <= '0;
            temp_valid       <= 1'b0;
            busy             <= 1'b0;
            nack_err         <= 1'b0;
            err_cnt          <= '0;
        end else begin
            temp_valid <= 1'b0;
            nack_err   <= 1'b0;
            case (state_reg)
                S_CFG: begin
                    i2c.i2c_cfg_data <= CMD_CFG;
                    i2c.i2c_start    <= 1'b1;
                    busy             <= 1'b1;
                    tmo_cnt_reg      <= '0;
                    state_reg        <= S_CFG_WAIT;
                end
                S_CFG_WAIT: begin
                    // done wins over a coincident timeout
                    if (i2c.i2c_done) begin
                        i2c.i2c_start <= 1'b0;
                        busy          <= 1'b0;
                        poll_cnt_reg  <= '0;
                        state_reg     <= S_IDLE;
                    end else if (tmo_hit) begin
                        i2c.i2c_start <= 1'b0;
                        busy          <= 1'b0;
                        ret_reg       <= S_CFG;
                        state_reg     <= S_ERR;
                    end else begin
                        tmo_cnt_reg <= tmo_cnt_reg + TW'(1);
                    end
                end
                S_IDLE: begin
                    // counter parks at its terminal value while enable is low
                    if (poll_cnt_reg == POLL_LAST) begin
                        if (enable) begin
                            state_reg <= S_RD_HI;
                        end
                    end else begin
                        poll_cnt_reg <= poll_cnt_reg + PW'(1);
                    end
                end
                S_RD_HI: begin
                    i2c.i2c_cfg_data <= CMD_RD_HI;
                    i2c.i2c_start    <= 1'b1;
                    busy             <= 1'b1;
                    tmo_cnt_reg      <= '0;
                    state_reg        <= S_RD_HI_WAIT;
                end
                S_RD_HI_WAIT: begin
                    if (i2c.i2c_done) begin
                        msb_reg       <= i2c.i2c_rd_data;
                        i2c.i2c_start <= 1'b0;
                        state_reg     <= S_GAP;
                    end else if (tmo_hit) begin
                        i2c.i2c_start <= 1'b0;
                        busy          <= 1'b0;
                        ret_reg       <= S_IDLE;
                        state_reg     <= S_ERR;
                    end else begin
                        tmo_cnt_reg <= tmo_cnt_reg + TW'(1);
                    end
                end
                S_GAP: begin
                    // one guaranteed low cycle on start between the two reads
                    state_reg <= S_RD_LO;
                end
                S_RD_LO: begin
                    i2c.i2c_cfg_data <= CMD_RD_LO;
                    i2c.i2c_start    <= 1'b1;
                    tmo_cnt_reg      <= '0;
                    state_reg        <= S_RD_LO_WAIT;
                end
                S_RD_LO_WAIT: begin
                    if (i2c.i2c_done) begin
                        temp_data     <= temp_next;
                        temp_valid    <= 1'b1;
                        i2c.i2c_start <= 1'b0;
                        busy          <= 1'b0;
                        poll_cnt_reg  <= '0;
                        state_reg     <= S_IDLE;
                    end else if (tmo_hit) begin
                        i2c.i2c_start <= 1'b0;
                        busy          <= 1'b0;
                        ret_reg       <= S_IDLE;
                        state_reg     <= S_ERR;
                    end else begin
                        tmo_cnt_reg <= tmo_cnt_reg + TW'(1);
                    end
                end
                S_ERR: begin
                    i2c.i2c_start <= 1'b0;
                    busy          <= 1'b0;
                    nack_err      <= 1'b1;
                    if (err_cnt != 8'hFF) begin
                        err_cnt <= err_cnt + 8'd1;
                    end
                    // a retry into S_IDLE waits a full poll interval
                    poll_cnt_reg  <= '0;
                    state_reg     <= ret_reg;
                end
                default: begin
                    state_reg <= S_CFG;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_temp_poll_seq.sv
// Directed bench for temp_poll_seq. Three instances with different poll and
// timeout settings: A (long timeout) for config/poll/enable/reset, B (short
// timeout) for timeout handling, C (tiny intervals) for error saturation.
module tb_temp_poll_seq;

    localparam int POLL_A = 100;
    localparam int TMO_A  = 10000;
    localparam int POLL_B = 100;
    localparam int TMO_B  = 200;
    localparam int POLL_C = 4;
    localparam int TMO_C  = 20;

    localparam logic [31:0] CMD_CFG   = {7'h48, 1'b0, 16'h0001, 8'h60};
    localparam logic [31:0] CMD_RD_HI = {7'h48, 1'b1, 16'h0000, 8'h00};
    localparam logic [31:0] CMD_RD_LO = {7'h48, 1'b1, 16'h0001, 8'h00};

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_a, rst_b, rst_c;
    logic en_a, en_b, en_c;
    logic [15:0] temp_a, temp_b, temp_c;
    logic tv_a, tv_b, tv_c;
    logic busy_a, busy_b, busy_c;
    logic nack_a, nack_b, nack_c;
    logic [7:0] ec_a, ec_b, ec_c;

    temp_poll_seq_if bus_a();
    temp_poll_seq_if bus_b();
    temp_poll_seq_if bus_c();

    temp_poll_seq #(.POLL_CYCLES(POLL_A), .TIMEOUT_CYCLES(TMO_A)) dut_a (
        .clk(clk), .rst(rst_a), .enable(en_a), .i2c(bus_a.master),
        .temp_data(temp_a), .temp_valid(tv_a), .busy(busy_a),
        .nack_err(nack_a), .err_cnt(ec_a));

    temp_poll_seq #(.POLL_CYCLES(POLL_B), .TIMEOUT_CYCLES(TMO_B)) dut_b (
        .clk(clk), .rst(rst_b), .enable(en_b), .i2c(bus_b.master),
        .temp_data(temp_b), .temp_valid(tv_b), .busy(busy_b),
        .nack_err(nack_b), .err_cnt(ec_b));

    temp_poll_seq #(.POLL_CYCLES(POLL_C), .TIMEOUT_CYCLES(TMO_C)) dut_c (
        .clk(clk), .rst(rst_c), .enable(en_c), .i2c(bus_c.master),
        .temp_data(temp_c), .temp_valid(tv_c), .busy(busy_c),
        .nack_err(nack_c), .err_cnt(ec_c));

    int checks = 0;
    int errors = 0;

    // Per-instance sample history (index 0 = A, 1 = B)
    logic [15:0] mh [2][4];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic get_start(input int w);
        return (w == 0) ? bus_a.i2c_start : bus_b.i2c_start;
    endfunction

    function automatic logic [31:0] get_cfg(input int w);
        return (w == 0) ? bus_a.i2c_cfg_data : bus_b.i2c_cfg_data;
    endfunction

    function automatic logic get_busy(input int w);
        return (w == 0) ? busy_a : busy_b;
    endfunction

    function automatic logic get_event(input int w);
        return (w == 0) ? (tv_a | nack_a) : (tv_b | nack_b);
    endfunction

    task automatic drive_done(input int w, input logic d, input logic [7:0] v);
        if (w == 0) begin
            bus_a.i2c_done = d;
            bus_a.i2c_rd_data = v;
        end else begin
            bus_b.i2c_done = d;
            bus_b.i2c_rd_data = v;
        end
    endtask

    task automatic model_clear(input int w);
        for (int i = 0; i < 4; i++) mh[w][i] = 16'h0000;
    endtask

    task automatic model_push(input int w, input logic [15:0] s, output logic [15:0] e);
        logic [17:0] sum;
        for (int i = 3; i > 0; i--) mh[w][i] = mh[w][i-1];
        mh[w][0] = s;
        sum = 18'h0;
        for (int i = 0; i < 4; i++) sum = sum + 18'(mh[w][i]);
`ifdef TEMP_AVG_EN
        e = sum[17:2];
`else
        e = mh[w][0];
`endif
    endtask

    // Controller stand-in: called with start already high; answers on the
    // delay-th high cycle (delay 0 = never), returns once start is low.
    task automatic serve(input int w, input logic [7:0] data, input int delay,
                         output int hi, output logic [31:0] cmd, output bit stable);
        hi = 0;
        stable = 1'b1;
        cmd = get_cfg(w);
        while (get_start(w) === 1'b1 && hi < 20000) begin
            hi++;
            if (get_cfg(w) !== cmd) stable = 1'b0;
            if (hi == delay) drive_done(w, 1'b1, data);
            tick();
            drive_done(w, 1'b0, 8'h00);
        end
    endtask

    // Ticks until start is high or limit expires; counts tv/nack samples seen
    task automatic wait_start(input int w, input int limit, output int n, output int ev);
        n = 0;
        ev = 0;
        while (get_start(w) !== 1'b1 && n < limit) begin
            tick();
            n++;
            if (get_event(w) === 1'b1) ev++;
        end
    endtask

    task automatic read_pair(input int w, input logic [7:0] msb, input logic [7:0] lsb,
                             input int delay, output logic [31:0] cmd_hi,
                             output logic [31:0] cmd_lo, output int gap, output bit gap_busy);
        int hi;
        bit st;
        serve(w, msb, delay, hi, cmd_hi, st);
        gap = 0;
        gap_busy = 1'b1;
        while (get_start(w) !== 1'b1 && gap < 20) begin
            if (get_busy(w) !== 1'b1) gap_busy = 1'b0;
            gap++;
            tick();
        end
        cmd_lo = 32'h0;
        if (get_start(w) === 1'b1) serve(w, lsb, delay, hi, cmd_lo, st);
    endtask

    task automatic test_reset();
        rst_a = 1'b1; rst_b = 1'b1; rst_c = 1'b1;
        en_a = 1'b1; en_b = 1'b1; en_c = 1'b1;
        drive_done(0, 1'b0, 8'h00);
        drive_done(1, 1'b0, 8'h00);
        bus_c.i2c_done = 1'b0;
        bus_c.i2c_rd_data = 8'h00;
        model_clear(0);
        model_clear(1);
        repeat (3) tick();
        checks++; if (bus_a.i2c_start !== 1'b0) begin errors++; $display("FAIL reset_start: got %b expected 0", bus_a.i2c_start); end
        checks++; if (bus_a.i2c_cfg_data !== 32'h0) begin errors++; $display("FAIL reset_cfg: got %h expected 00000000", bus_a.i2c_cfg_data); end
        checks++; if (temp_a !== 16'h0) begin errors++; $display("FAIL reset_temp: got %h expected 0000", temp_a); end
        checks++; if ({tv_a, busy_a, nack_a} !== 3'b000) begin errors++; $display("FAIL reset_flags: got %b expected 000", {tv_a, busy_a, nack_a}); end
        checks++; if (ec_a !== 8'h0) begin errors++; $display("FAIL reset_err_cnt: got %h expected 00", ec_a); end
        $display("reset: outputs of A checked");
    endtask

    task automatic test_config();
        int hi;
        logic [31:0] cmd;
        bit st;
        rst_a = 1'b0;
        tick();
        checks++; if (bus_a.i2c_start !== 1'b1) begin errors++; $display("FAIL cfg_start: got %b expected 1", bus_a.i2c_start); end
        checks++; if (bus_a.i2c_cfg_data !== CMD_CFG) begin errors++; $display("FAIL cfg_word: got %h expected %h", bus_a.i2c_cfg_data, CMD_CFG); end
        checks++; if (busy_a !== 1'b1) begin errors++; $display("FAIL cfg_busy: got %b expected 1", busy_a); end
        serve(0, 8'h00, 7500, hi, cmd, st);
        checks++; if (hi !== 7500) begin errors++; $display("FAIL cfg_start_len: got %0d expected 7500", hi); end
        checks++; if (st !== 1'b1) begin errors++; $display("FAIL cfg_word_stable: got %b expected 1", st); end
        checks++; if ({bus_a.i2c_start, busy_a, nack_a} !== 3'b000) begin errors++; $display("FAIL cfg_end_flags: got %b expected 000", {bus_a.i2c_start, busy_a, nack_a}); end
        $display("config: cmd=%h start_high=%0d", cmd, hi);
    endtask

    task automatic test_poll();
        logic [7:0] msb_v [2];
        logic [7:0] lsb_v [2];
        int dly [2];
        int n, ev, gap;
        bit gb;
        logic [31:0] ch, cl;
        logic [15:0] e;
        msb_v[0] = 8'h19; lsb_v[0] = 8'h80; dly[0] = 5;
        msb_v[1] = 8'hE7; lsb_v[1] = 8'h0F; dly[1] = 1;
        for (int k = 0; k < 2; k++) begin
            wait_start(0, 300, n, ev);
            checks++; if (n !== POLL_A + 1) begin errors++; $display("FAIL poll_interval: got %0d expected %0d", n, POLL_A + 1); end
            checks++; if (ev !== 0) begin errors++; $display("FAIL poll_stray_event: got %0d expected 0", ev); end
            read_pair(0, msb_v[k], lsb_v[k], dly[k], ch, cl, gap, gb);
            model_push(0, {msb_v[k], lsb_v[k]}, e);
            checks++; if (ch !== CMD_RD_HI) begin errors++; $display("FAIL poll_cmd_hi: got %h expected %h", ch, CMD_RD_HI); end
            checks++; if (cl !== CMD_RD_LO) begin errors++; $display("FAIL poll_cmd_lo: got %h expected %h", cl, CMD_RD_LO); end
            checks++; if (gap !== 2) begin errors++; $display("FAIL poll_gap: got %0d expected 2", gap); end
            checks++; if (gb !== 1'b1) begin errors++; $display("FAIL poll_gap_busy: got %b expected 1", gb); end
            checks++; if (tv_a !== 1'b1) begin errors++; $display("FAIL poll_valid: got %b expected 1", tv_a); end
            checks++; if (temp_a !== e) begin errors++; $display("FAIL poll_temp: got %h expected %h", temp_a, e); end
            $display("poll: msb=%h lsb=%h temp=%h", msb_v[k], lsb_v[k], temp_a);
        end
    endtask

    task automatic test_enable();
        int n, ev, gap;
        bit gb;
        logic [31:0] ch, cl;
        logic [15:0] e;
        wait_start(0, 300, n, ev);
        checks++; if (n !== POLL_A + 1) begin errors++; $display("FAIL en_interval: got %0d expected %0d", n, POLL_A + 1); end
        en_a = 1'b0;
        read_pair(0, 8'h21, 8'h40, 4, ch, cl, gap, gb);
        model_push(0, 16'h2140, e);
        checks++; if (cl !== CMD_RD_LO) begin errors++; $display("FAIL en_lsb_issued: got %h expected %h", cl, CMD_RD_LO); end
        checks++; if (tv_a !== 1'b1) begin errors++; $display("FAIL en_valid: got %b expected 1", tv_a); end
        checks++; if (temp_a !== e) begin errors++; $display("FAIL en_temp: got %h expected %h", temp_a, e); end
        wait_start(0, 300, n, ev);
        checks++; if (n !== 300) begin errors++; $display("FAIL en_idle_hold: got %0d expected 300", n); end
        en_a = 1'b1;
        wait_start(0, 10, n, ev);
        checks++; if (n !== 2) begin errors++; $display("FAIL en_restart: got %0d expected 2", n); end
        read_pair(0, 8'h05, 8'hAA, 3, ch, cl, gap, gb);
        model_push(0, 16'h05AA, e);
        checks++; if (temp_a !== e) begin errors++; $display("FAIL en_resume_temp: got %h expected %h", temp_a, e); end
        $display("enable: held idle, resumed, temp=%h", temp_a);
    endtask

    task automatic test_reset_mid();
        int n, ev, hi;
        logic [31:0] cmd;
        bit st;
        wait_start(0, 300, n, ev);
        rst_a = 1'b1;
        tick();
        checks++; if ({bus_a.i2c_start, busy_a} !== 2'b00) begin errors++; $display("FAIL rstmid_start: got %b expected 00", {bus_a.i2c_start, busy_a}); end
        checks++; if (temp_a !== 16'h0) begin errors++; $display("FAIL rstmid_temp: got %h expected 0000", temp_a); end
        rst_a = 1'b0;
        model_clear(0);
        tick();
        checks++; if (bus_a.i2c_start !== 1'b1 || bus_a.i2c_cfg_data !== CMD_CFG) begin errors++; $display("FAIL rstmid_recfg: got %b/%h expected 1/%h", bus_a.i2c_start, bus_a.i2c_cfg_data, CMD_CFG); end
        serve(0, 8'h00, 10, hi, cmd, st);
        $display("reset_mid: config reissued cmd=%h", cmd);
    endtask

`ifdef TEMP_AVG_EN
    task automatic test_avg();
        logic [15:0] exp_tab [4];
        int n, ev, gap;
        bit gb;
        logic [31:0] ch, cl;
        logic [15:0] e;
        exp_tab[0] = 16'h0040; exp_tab[1] = 16'h00C0;
        exp_tab[2] = 16'h0180; exp_tab[3] = 16'h0280;
        for (int k = 0; k < 4; k++) begin
            wait_start(0, 300, n, ev);
            read_pair(0, 8'(k + 1), 8'h00, 3, ch, cl, gap, gb);
            model_push(0, {8'(k + 1), 8'h00}, e);
            checks++; if (temp_a !== exp_tab[k]) begin errors++; $display("FAIL avg_temp: got %h expected %h", temp_a, exp_tab[k]); end
            $display("avg: sample=%h temp=%h", {8'(k + 1), 8'h00}, temp_a);
        end
    endtask
`endif

    task automatic test_timeout();
        int n, ev, hi, gap;
        bit gb, st;
        logic [31:0] ch, cl, cmd;
        logic [15:0] e;
        rst_b = 1'b0;
        tick();
        serve(1, 8'h00, 3, hi, cmd, st);
        wait_start(1, 300, n, ev);
        read_pair(1, 8'h2A, 8'h55, 2, ch, cl, gap, gb);
        model_push(1, 16'h2A55, e);
        checks++; if (temp_b !== e) begin errors++; $display("FAIL tmo_pre_temp: got %h expected %h", temp_b, e); end
        wait_start(1, 300, n, ev);
        serve(1, 8'h00, 0, hi, cmd, st);
        checks++; if (hi !== TMO_B) begin errors++; $display("FAIL tmo_start_len: got %0d expected %0d", hi, TMO_B); end
        tick();
        checks++; if (nack_b !== 1'b1) begin errors++; $display("FAIL tmo_nack: got %b expected 1", nack_b); end
        checks++; if (ec_b !== 8'h01) begin errors++; $display("FAIL tmo_err_cnt: got %h expected 01", ec_b); end
        checks++; if (temp_b !== e) begin errors++; $display("FAIL tmo_temp_kept: got %h expected %h", temp_b, e); end
        checks++; if (busy_b !== 1'b0) begin errors++; $display("FAIL tmo_busy: got %b expected 0", busy_b); end
        wait_start(1, 300, n, ev);
        checks++; if (n !== POLL_B + 1) begin errors++; $display("FAIL tmo_retry_interval: got %0d expected %0d", n, POLL_B + 1); end
        checks++; if (ev !== 0) begin errors++; $display("FAIL tmo_nack_width: got %0d extra events expected 0", ev); end
        // done arriving on the very cycle the timeout would fire
        read_pair(1, 8'h3C, 8'hC3, TMO_B, ch, cl, gap, gb);
        model_push(1, 16'h3CC3, e);
        checks++; if (gap !== 2) begin errors++; $display("FAIL tmo_edge_gap: got %0d expected 2", gap); end
        checks++; if (tv_b !== 1'b1 || temp_b !== e) begin errors++; $display("FAIL tmo_edge_temp: got %b/%h expected 1/%h", tv_b, temp_b, e); end
        checks++; if (ec_b !== 8'h01 || nack_b !== 1'b0) begin errors++; $display("FAIL tmo_edge_err: got %h/%b expected 01/0", ec_b, nack_b); end
        $display("timeout: err_cnt=%h temp=%h", ec_b, temp_b);
    endtask

    task automatic test_saturate();
        int n = 0;
        int cyc = 0;
        logic [7:0] e;
        rst_c = 1'b0;
        while (n < 260 && cyc < 8000) begin
            tick();
            cyc++;
            if (nack_c === 1'b1) begin
                n++;
                e = (n > 255) ? 8'hFF : 8'(n);
                checks++; if (ec_c !== e) begin errors++; $display("FAIL sat_err_cnt: got %h expected %h at timeout %0d", ec_c, e, n); end
            end
        end
        checks++; if (n !== 260) begin errors++; $display("FAIL sat_timeouts: got %0d expected 260", n); end
        checks++; if (ec_c !== 8'hFF) begin errors++; $display("FAIL sat_final: got %h expected ff", ec_c); end
        $display("saturate: timeouts=%0d err_cnt=%h", n, ec_c);
    endtask

    initial begin
        test_reset();
        test_config();
        test_poll();
        test_enable();
        test_reset_mid();
`ifdef TEMP_AVG_EN
        test_avg();
`endif
        test_timeout();
        test_saturate();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/temp_poll_seq.md
Name: temp_poll_seq

Overview:
Transaction sequencer that sits directly upstream of the I2C temperature controller in the fan-control path. After reset it issues one configuration write to the sensor. It then polls the temperature MSB and LSB registers at a fixed interval. Each transaction is driven through the controller's 32-bit command word and i2c_start/i2c_done handshake, and the result is presented as a 16-bit temperature word for the downstream fan-speed logic.

Parameters:
DEV_ADDR, 7'h48, 7-bit sensor device address.
CFG_REG, 16'h0001, register address for the init write (sent as reg_addr1 then reg_addr2).
CFG_VAL, 8'h60, data byte for the init write.
TEMP_REG_MSB, 16'h0000, register address of temperature MSB.
TEMP_REG_LSB, 16'h0001, register address of temperature LSB.
POLL_CYCLES, 5000000, clk cycles between poll starts (100 ms at 50 MHz); must be at least 2.
TIMEOUT_CYCLES, 50000, maximum clk cycles from i2c_start assertion to i2c_done.

Ports:
clk  in  1  system clock (50 MHz)
rst  in  1  synchronous, active-high reset
enable  in  1  1 = polling allowed; 0 = finish current transaction, then idle
i2c_done  in  1  one-cycle pulse from the controller at the end of a transaction
i2c_rd_data  in  8  read byte from the controller, valid when i2c_done pulses on a read
i2c_start  out  1  level request to the controller
i2c_cfg_data  out  32  command word: [31:25] DEV_ADDR, [24] rd flag (1 = read), [23:16] reg addr high, [15:8] reg addr low, [7:0] write data (0 for reads)
temp_data  out  16  latest temperature, {MSB, LSB}
temp_valid  out  1  one-cycle pulse when temp_data updates
busy  out  1  high when a transaction is outstanding
nack_err  out  1  one-cycle pulse on transaction timeout
err_cnt  out  8  saturating count of timeouts

Behaviour:
- Interface: one clock, clk. Reset rst is synchronous and active-high. All outputs are registered.
- Reset values:
  - i2c_start = 0, i2c_cfg_data = 0, temp_data = 0, temp_valid = 0, busy = 0, nack_err = 0, err_cnt = 0.
  - State = S_CFG, poll/timeout counters cleared.
- States:
  - S_CFG: load the write command {DEV_ADDR, 0, CFG_REG, CFG_VAL}, set i2c_start = 1 and busy = 1, clear the timeout counter, go to S_CFG_WAIT.
  - S_CFG_WAIT: on i2c_done, clear i2c_start and go to S_IDLE (poll counter cleared). On timeout, go to S_ERR with return target S_CFG.
  - S_IDLE: poll counter increments each cycle. When it reaches POLL_CYCLES-1 and enable = 1, go to S_RD_HI. If enable = 0, hold the counter at its terminal value.
  - S_RD_HI: load {DEV_ADDR, 1, TEMP_REG_MSB, 8'h00}, assert i2c_start, go to S_RD_HI_WAIT.
  - S_RD_HI_WAIT: on i2c_done, latch i2c_rd_data into msb_r, deassert i2c_start, go to S_GAP. On timeout, go to S_ERR with return target S_IDLE.
  - S_GAP: exactly 1 cycle with i2c_start = 0, then S_RD_LO. This guarantees start is seen low between transactions.
  - S_RD_LO: same as S_RD_HI using TEMP_REG_LSB; proceeds to S_RD_LO_WAIT.
  - S_RD_LO_WAIT: on i2c_done, temp_data <= {msb_r, i2c_rd_data} and temp_valid pulses in the following cycle; go to S_IDLE. On timeout, go to S_ERR with return target S_IDLE.
  - S_ERR: i2c_start = 0, busy = 0, nack_err pulses 1 cycle, err_cnt += 1 (saturates at 255). Go to the return target; S_IDLE clears the poll counter so the retry waits one full interval. temp_data is not modified.
- Handshake and timeout:
  - i2c_start deasserts in the cycle after i2c_done is sampled.
  - i2c_done outside a WAIT state is ignored.
  - Timeout fires when the counter equals TIMEOUT_CYCLES-1 while still in a WAIT state. This covers a controller NACK, which returns to idle without i2c_done.
- busy is 1 from the S_CFG/S_RD_HI entry cycle until leaving the final WAIT state of that sequence, including S_GAP.
- i2c_cfg_data is held stable for the whole time i2c_start = 1.
- Simultaneous events: i2c_done in the same cycle as timeout is treated as success and no error is recorded.
- enable is only sampled in S_IDLE. Deasserting it mid-read lets the MSB+LSB pair complete.
- rst mid-transaction returns to S_CFG with i2c_start = 0 in the next cycle, so the config write is reissued.

Optional Feature:
TEMP_AVG_EN
- Defined: temp_data is the mean of the last 4 completed samples.
  - 4-entry shift register, 18-bit sum, result = sum >> 2, truncated.
  - The first 3 samples after reset average against the zero-initialised entries.
  - temp_valid timing is unchanged.
- Undefined: temp_data is the raw latest sample; no averaging logic exists.

Test Plan:
- Reset release, responder returns done after 7500 cycles -> first command word {7'h48, 0, 16'h0001, 8'h60}, i2c_start held 7500 cycles then low, busy falls, S_IDLE entered.
- Poll cycle with POLL_CYCLES = 100, responder returns MSB 8'h19 then LSB 8'h80 -> two read commands (addr 16'h0000 then 16'h0001, bit 24 = 1), at least one low start cycle between them, temp_data = 16'h1980, single temp_valid pulse.
- No i2c_done on the MSB read, TIMEOUT_CYCLES = 200 -> i2c_start drops 200 cycles after assertion, nack_err one pulse, err_cnt = 1, temp_data unchanged, next read after POLL_CYCLES.
- 260 consecutive timeouts -> err_cnt saturates at 8'hFF, no wrap.
- enable dropped during S_RD_HI_WAIT -> LSB read still issued, temp_valid pulses, no new read while enable = 0; re-asserting enable -> read starts next cycle.
- TEMP_AVG_EN defined, samples 16'h0100, 0200, 0300, 0400 -> temp_data 0040, 00C0, 0180, 0280.
